// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one 3-input XOR parity datapath among NREQ requesters.
// A granted word is reduced 3 bits per cycle; the result returns with a one-cycle done pulse.
module parity_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data,
  input  logic                     odd_mode,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic                     parity_out,
  output logic [$clog2(NREQ)-1:0]  done_id
);

  localparam int NSTEP = (WIDTH + 2) / 3;
  localparam int SRW   = 3 * NSTEP;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam int IDW   = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [SRW-1:0]   sr_q;
  logic             acc_q;
  logic [CW-1:0]    cnt_q;
  logic             odd_q;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q;
  logic             done_q;
  logic             parity_q;
  logic [IDW-1:0]   done_id_q;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   winner_q;

  logic [WIDTH-1:0] words [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign words[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search starting just after the last winner.
  logic             pick_found_d;
  logic [IDW-1:0]   pick_idx_d;
  logic [IDW-1:0]   cand_d;
  int               idx_int_d;

  always_comb begin
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    cand_d       = '0;
    idx_int_d    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_int_d = int'(last_q) + k;
      if (idx_int_d >= NREQ) begin
        idx_int_d = idx_int_d - NREQ;
      end
      cand_d = IDW'(idx_int_d);
      if (!pick_found_d && req[cand_d]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = cand_d;
      end
    end
  end

  logic [NREQ-1:0] gnt_d;
  logic            acc_d;
  logic [SRW-1:0]  sr_d;

  always_comb begin
    gnt_d = NREQ'(1) << pick_idx_d;
    acc_d = acc_q ^ sr_q[0] ^ sr_q[1] ^ sr_q[2];
    sr_d  = SRW'(words[pick_idx_d]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      odd_q     <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
      done_id_q <= '0;
      last_q    <= IDW'(NREQ - 1);
      winner_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (pick_found_d) begin
            sr_q     <= sr_d;
            odd_q    <= odd_mode;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= gnt_d;
            busy_q   <= 1'b1;
            last_q   <= pick_idx_d;
            winner_q <= pick_idx_d;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          // Dropping req aborts silently; the pointer stays advanced past this requester.
          if (!req[winner_q]) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            sr_q  <= sr_q >> 3;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(NSTEP - 1)) begin
              done_q    <= 1'b1;
              parity_q  <= acc_d ^ odd_q;
              done_id_q <= winner_q;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_out = parity_q;
  assign done_id    = done_id_q;

endmodule
